// File: rtl/beat_gen.sv
// Phase/beat timing generator feeding the hardwired controller: T1..T3 phases, W1..W3 beats,
// run/halt control and an instruction-cycle counter. Define BEAT_GEN_SSTEP_EN to add the SSTEP input.
module beat_gen #(
  parameter int CLK_DIV      = 1,
  parameter bit RUN_ON_RESET = 1'b0,
  parameter int ICNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              SHORT,
  input  logic              LONG,
  input  logic              STOP,
`ifdef BEAT_GEN_SSTEP_EN
  input  logic              SSTEP,
`endif
  output logic [2:0]        T,
  output logic [2:0]        W,
  output logic              RUN,
  output logic [ICNT_W-1:0] ICNT
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Encodings are the one-hot output patterns, so T and W come straight off the registers
  typedef enum logic [2:0] {
    PH_T1 = 3'b001,
    PH_T2 = 3'b010,
    PH_T3 = 3'b100
  } phase_t;

  typedef enum logic [2:0] {
    BT_W1 = 3'b001,
    BT_W2 = 3'b010,
    BT_W3 = 3'b100
  } beat_t;

  logic [DIV_W-1:0]  div_cnt, div_nxt;
  phase_t            phase, phase_nxt;
  beat_t             beat, beat_nxt, beat_sel;
  logic              run_q, run_nxt;
  logic [ICNT_W-1:0] icnt, icnt_nxt;
  logic              tick, beat_end, step_halt;

  assign tick     = run_q && (div_cnt == DIV_LAST);
  assign beat_end = tick && (phase == PH_T3);

  // Controller requests only matter at a beat end; elsewhere beat_sel is simply unused
  always_comb begin
    beat_sel = BT_W1;
    case (beat)
      BT_W1:   beat_sel = SHORT ? BT_W1 : BT_W2;
      BT_W2:   beat_sel = LONG ? BT_W3 : BT_W1;
      default: beat_sel = BT_W1;
    endcase
  end

`ifdef BEAT_GEN_SSTEP_EN
  assign step_halt = SSTEP && (beat_sel == BT_W1);
`else
  assign step_halt = 1'b0;
`endif

  always_comb begin
    div_nxt   = div_cnt;
    phase_nxt = phase;
    beat_nxt  = beat;
    run_nxt   = run_q;
    icnt_nxt  = icnt;
    if (run_q) begin
      if (tick) begin
        div_nxt = '0;
        case (phase)
          PH_T1:   phase_nxt = PH_T2;
          PH_T2:   phase_nxt = PH_T3;
          default: phase_nxt = PH_T1;
        endcase
      end else begin
        div_nxt = div_cnt + DIV_W'(1);
      end
      // A halting beat end already wraps the phase back to T1 above
      if (beat_end) begin
        beat_nxt = beat_sel;
        if (beat_sel == BT_W1)
          icnt_nxt = icnt + ICNT_W'(1);
        if (STOP || step_halt)
          run_nxt = 1'b0;
      end
    end else if (START) begin
      run_nxt   = 1'b1;
      div_nxt   = '0;
      phase_nxt = PH_T1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt <= '0;
      phase   <= PH_T1;
      beat    <= BT_W1;
      run_q   <= RUN_ON_RESET;
      icnt    <= '0;
    end else begin
      div_cnt <= div_nxt;
      phase   <= phase_nxt;
      beat    <= beat_nxt;
      run_q   <= run_nxt;
      icnt    <= icnt_nxt;
    end
  end

  assign T    = run_q ? phase : 3'b000;
  assign W    = beat;
  assign RUN  = run_q;
  assign ICNT = icnt;

endmodule

// File: tb/tb_beat_gen.sv
// Self-checking bench for beat_gen: a constant vector table, directed corner sequences and
// randomized traffic checked against a clock-position model, on two differently configured instances.
module tb_beat_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, start = 1'b0, short_in = 1'b0, long_in = 1'b0, stop = 1'b0;
  logic sstep = 1'b0;

  logic [2:0]  t0, w0, t1, w1;
  logic        run0, run1;
  logic [15:0] icnt0;
  logic [3:0]  icnt1;

  beat_gen #(.CLK_DIV(1), .RUN_ON_RESET(1'b0), .ICNT_W(16)) dut0 (
    .CLK(clk), .RST(rst), .START(start), .SHORT(short_in), .LONG(long_in), .STOP(stop),
`ifdef BEAT_GEN_SSTEP_EN
    .SSTEP(sstep),
`endif
    .T(t0), .W(w0), .RUN(run0), .ICNT(icnt0)
  );

  beat_gen #(.CLK_DIV(2), .RUN_ON_RESET(1'b1), .ICNT_W(4)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .SHORT(short_in), .LONG(long_in), .STOP(stop),
`ifdef BEAT_GEN_SSTEP_EN
    .SSTEP(sstep),
`endif
    .T(t1), .W(w1), .RUN(run1), .ICNT(icnt1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position in the beat counted in raw clocks, beat as 1..3
  int m_div[2]  = '{1, 2};
  int m_mask[2] = '{32'hFFFF, 32'hF};
  bit m_ror[2]  = '{1'b0, 1'b1};
  bit m_run[2]  = '{1'b0, 1'b1};
  int m_pos[2]  = '{0, 0};
  int m_beat[2] = '{1, 1};
  int m_icnt[2] = '{0, 0};

  task automatic model_step();
    int nb;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pos[k] = 0; m_beat[k] = 1; m_run[k] = m_ror[k]; m_icnt[k] = 0;
      end else if (m_run[k]) begin
        if (m_pos[k] == 3 * m_div[k] - 1) begin
          if (m_beat[k] == 1)      nb = short_in ? 1 : 2;
          else if (m_beat[k] == 2) nb = long_in ? 3 : 1;
          else                     nb = 1;
          if (nb == 1) m_icnt[k] = (m_icnt[k] + 1) & m_mask[k];
          m_beat[k] = nb;
          m_pos[k]  = 0;
          if (stop || (sstep && nb == 1)) m_run[k] = 1'b0;
        end else begin
          m_pos[k]++;
        end
      end else if (start) begin
        m_run[k] = 1'b1;
        m_pos[k] = 0;
      end
    end
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic check_model(input int k, input string tag);
    int et;
    et = m_run[k] ? (1 << (m_pos[k] / m_div[k])) : 0;
    if (k == 0) begin
      check_output({tag, " dut0 T"}, int'(t0), et);
      check_output({tag, " dut0 W"}, int'(w0), 1 << (m_beat[0] - 1));
      check_output({tag, " dut0 RUN"}, int'(run0), int'(m_run[0]));
      check_output({tag, " dut0 ICNT"}, int'(icnt0), m_icnt[0]);
    end else begin
      check_output({tag, " dut1 T"}, int'(t1), et);
      check_output({tag, " dut1 W"}, int'(w1), 1 << (m_beat[1] - 1));
      check_output({tag, " dut1 RUN"}, int'(run1), int'(m_run[1]));
      check_output({tag, " dut1 ICNT"}, int'(icnt1), m_icnt[1]);
    end
  endtask

  // Drive one clock worth of inputs, advance the model at the edge, return at the falling edge
  task automatic apply_stimulus(input bit r, input bit s, input bit sh, input bit lg, input bit sp);
    rst = r; start = s; short_in = sh; long_in = lg; stop = sp;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    bit       r, s, sh, lg, sp;
    logic [2:0] t, w;
    bit       run;
    int       icnt;
  } vec_t;

  function automatic vec_t mk(input bit r, input bit s, input bit sh, input bit lg, input bit sp,
                              input logic [2:0] t, input logic [2:0] w, input bit run, input int ic);
    vec_t v;
    v.r = r; v.s = s; v.sh = sh; v.lg = lg; v.sp = sp;
    v.t = t; v.w = w; v.run = run; v.icnt = ic;
    return v;
  endfunction

  localparam int NVEC = 23;
  vec_t tbl[NVEC];

  initial begin
    int n;
    // Expected outputs of dut0 (CLK_DIV=1, halted after reset) after each clock
    tbl[0]  = mk(1, 0, 0, 0, 0, 3'b000, 3'b001, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 3'b000, 3'b001, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 3'b001, 3'b001, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 3'b010, 3'b001, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 3'b100, 3'b001, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 3'b001, 3'b010, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 3'b010, 3'b010, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 3'b100, 3'b010, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 3'b001, 3'b001, 1, 1);
    tbl[9]  = mk(0, 1, 0, 0, 0, 3'b010, 3'b001, 1, 1);
    tbl[10] = mk(0, 0, 1, 0, 0, 3'b100, 3'b001, 1, 1);
    tbl[11] = mk(0, 0, 1, 0, 0, 3'b001, 3'b001, 1, 2);
    tbl[12] = mk(0, 0, 0, 1, 0, 3'b010, 3'b001, 1, 2);
    tbl[13] = mk(0, 0, 0, 0, 0, 3'b100, 3'b001, 1, 2);
    tbl[14] = mk(0, 0, 0, 0, 1, 3'b000, 3'b010, 0, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 3'b000, 3'b010, 0, 2);
    tbl[16] = mk(0, 1, 0, 0, 0, 3'b001, 3'b010, 1, 2);
    tbl[17] = mk(0, 0, 0, 0, 0, 3'b010, 3'b010, 1, 2);
    tbl[18] = mk(0, 0, 0, 0, 0, 3'b100, 3'b010, 1, 2);
    tbl[19] = mk(0, 0, 1, 1, 0, 3'b001, 3'b100, 1, 2);
    tbl[20] = mk(0, 0, 0, 0, 0, 3'b010, 3'b100, 1, 2);
    tbl[21] = mk(0, 0, 0, 0, 0, 3'b100, 3'b100, 1, 2);
    tbl[22] = mk(0, 0, 1, 1, 0, 3'b001, 3'b001, 1, 3);

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(tbl[i].r, tbl[i].s, tbl[i].sh, tbl[i].lg, tbl[i].sp);
      check_output($sformatf("vec%0d T", i), int'(t0), int'(tbl[i].t));
      check_output($sformatf("vec%0d W", i), int'(w0), int'(tbl[i].w));
      check_output($sformatf("vec%0d RUN", i), int'(run0), int'(tbl[i].run));
      check_output($sformatf("vec%0d ICNT", i), int'(icnt0), tbl[i].icnt);
      check_model(1, "table");
    end

    // SHORT held: W1 repeats, one instruction per 3 clocks
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(0, 0, 1, 0, 0);
      check_output("short_hold W", int'(w0), 1);
      check_model(0, "short_hold");
      check_model(1, "short_hold");
    end
    check_output("short_hold ICNT", int'(icnt0), 8);

    // STOP at W1 T3, hold halted, then restart in the preselected W2
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    check_output("stop T", int'(t0), 0);
    check_output("stop W", int'(w0), 3'b010);
    check_output("stop RUN", int'(run0), 0);
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(0, 0, 0, 0, 0);
      check_output("halt_hold T", int'(t0), 0);
      check_output("halt_hold W", int'(w0), 3'b010);
      check_model(1, "halt_hold");
    end
    apply_stimulus(0, 1, 0, 0, 0);
    check_output("restart T", int'(t0), 3'b001);
    check_output("restart W", int'(w0), 3'b010);
    check_model(1, "restart");

    // Reset dut1 in the middle of W2 T2 with LONG pending
    n = 0;
    while (!(m_run[1] && m_beat[1] == 2 && (m_pos[1] / 2) == 1) && n < 40) begin
      apply_stimulus(0, !m_run[1], 0, 1, 0);
      n++;
    end
    check_output("reach_w2t2 timeout", int'(n < 40), 1);
    apply_stimulus(1, 0, 0, 1, 0);
    check_output("midbeat_rst T", int'(t1), 3'b001);
    check_output("midbeat_rst W", int'(w1), 3'b001);
    check_output("midbeat_rst ICNT", int'(icnt1), 0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0, 0, 0, 1, 0);
      check_output("no_w3 after rst", int'(w1 == 3'b100), 0);
      check_model(1, "post_rst");
    end

`ifdef BEAT_GEN_SSTEP_EN
    // Single-step: dut1 completes its first cycle and halts, then one START gives one cycle
    sstep = 1'b1;
    apply_stimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(0, 0, 0, 0, 0);
      check_model(1, "sstep_pre");
    end
    check_output("sstep first halt", int'(run1), 0);
    apply_stimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 11; i++) apply_stimulus(0, 0, 0, 0, 0);
    check_output("sstep running", int'(run1), 1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("sstep RUN", int'(run1), 0);
    check_output("sstep W", int'(w1), 3'b001);
    check_output("sstep ICNT", int'(icnt1), 2);
    check_model(0, "sstep");
    sstep = 1'b0;
`endif

    // Randomized traffic against the model on both instances
    for (int i = 0; i < 3000; i++) begin
`ifdef BEAT_GEN_SSTEP_EN
      sstep = ($urandom_range(3) == 0);
`endif
      apply_stimulus($urandom_range(63) == 0, $urandom_range(3) == 0, 1'($urandom),
                     1'($urandom), $urandom_range(7) == 0);
      check_model(0, "random");
      check_model(1, "random");
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
